// File: rtl/video_pkg.sv
// Shared definitions for the video output path: default 800x480 timing,
// controller state encoding and the packed pixel type.
package video_pkg;

    localparam int unsigned DEFAULT_HDISP  = 32'd800;
    localparam int unsigned DEFAULT_HFP    = 32'd40;
    localparam int unsigned DEFAULT_HPULSE = 32'd48;
    localparam int unsigned DEFAULT_HBP    = 32'd40;
    localparam int unsigned DEFAULT_VDISP  = 32'd480;
    localparam int unsigned DEFAULT_VFP    = 32'd13;
    localparam int unsigned DEFAULT_VPULSE = 32'd3;
    localparam int unsigned DEFAULT_VBP    = 32'd29;

    typedef enum logic [0:0] {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } vga_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;

    // True when v lies in the half-open window [lo, lo+len).
    function automatic logic in_span(input int unsigned v,
                                     input int unsigned lo,
                                     input int unsigned len);
        return (v >= lo) && (v < (lo + len));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster generator: waits for the pixel FIFO to fill once, then
// free-runs the raster, popping one pixel per active position.
module vga_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned HDISP  = DEFAULT_HDISP,
    parameter int unsigned HFP    = DEFAULT_HFP,
    parameter int unsigned HPULSE = DEFAULT_HPULSE,
    parameter int unsigned HBP    = DEFAULT_HBP,
    parameter int unsigned VDISP  = DEFAULT_VDISP,
    parameter int unsigned VFP    = DEFAULT_VFP,
    parameter int unsigned VPULSE = DEFAULT_VPULSE,
    parameter int unsigned VBP    = DEFAULT_VBP
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    input  logic        fifo_wfull,
    output logic        fifo_read,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned H_TOTAL      = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned V_TOTAL      = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned HW           = $clog2(H_TOTAL);
    localparam int unsigned VW           = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 32'd1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 32'd1);
    localparam logic [HW-1:0] H_ZERO     = {HW{1'b0}};
    localparam logic [VW-1:0] V_ZERO     = {VW{1'b0}};
    localparam int unsigned H_SYNC_START = HDISP + HFP;
    localparam int unsigned V_SYNC_START = VDISP + VFP;

    vga_state_t    state_r;
    vga_state_t    state_nxt_s;
    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] hcnt_nxt_s;
    logic [VW-1:0] vcnt_r;
    logic [VW-1:0] vcnt_nxt_s;

    logic run_s;
    logic active_s;
    logic hsync_s;
    logic vsync_s;
    logic pop_s;

    logic hs_r;
    logic vs_r;
    logic de_r;
    rgb_t rgb_r;
    logic frame_start_r;
    logic underflow_r;

    logic hs_nxt_s;
    logic vs_nxt_s;
    logic de_nxt_s;
    rgb_t rgb_nxt_s;
    logic frame_start_nxt_s;
    logic underflow_nxt_s;

    // Controller next state: one-way hand-off from fill wait into free-run.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_FILL: begin
                if (fifo_wfull) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WAIT_FILL;
                end
            end
            RUN:       state_nxt_s = RUN;
            default:   state_nxt_s = WAIT_FILL;
        endcase
    end

    // Raster counters: held at the origin until running, then wrap per line/frame.
    always_comb begin
        hcnt_nxt_s = H_ZERO;
        vcnt_nxt_s = V_ZERO;
        if (state_r == RUN) begin
            if (hcnt_r == H_LAST) begin
                hcnt_nxt_s = H_ZERO;
                if (vcnt_r == V_LAST) begin
                    vcnt_nxt_s = V_ZERO;
                end else begin
                    vcnt_nxt_s = vcnt_r + VW'(1);
                end
            end else begin
                hcnt_nxt_s = hcnt_r + HW'(1);
                vcnt_nxt_s = vcnt_r;
            end
        end else begin
            hcnt_nxt_s = H_ZERO;
            vcnt_nxt_s = V_ZERO;
        end
    end

    // State and raster position registers.
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state_r <= WAIT_FILL;
            hcnt_r  <= H_ZERO;
            vcnt_r  <= V_ZERO;
        end else begin
            state_r <= state_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
            vcnt_r  <= vcnt_nxt_s;
        end
    end

    assign run_s    = (state_r == RUN);
    assign active_s = run_s
                      && in_span(32'(hcnt_r), 32'd0, HDISP)
                      && in_span(32'(vcnt_r), 32'd0, VDISP);
    assign hsync_s  = in_span(32'(hcnt_r), H_SYNC_START, HPULSE);
    assign vsync_s  = in_span(32'(vcnt_r), V_SYNC_START, VPULSE);
    // The pop must be combinational so the show-ahead head advances in step with the raster.
    assign pop_s    = active_s && !fifo_empty;

    // Next video output values; an empty FIFO on an active pixel shows black and is latched.
    always_comb begin
        hs_nxt_s          = 1'b1;
        vs_nxt_s          = 1'b1;
        de_nxt_s          = 1'b0;
        rgb_nxt_s         = RGB_BLACK;
        frame_start_nxt_s = 1'b0;
        underflow_nxt_s   = underflow_r;
        if (run_s) begin
            hs_nxt_s          = ~hsync_s;
            vs_nxt_s          = ~vsync_s;
            de_nxt_s          = active_s;
            frame_start_nxt_s = (hcnt_r == H_ZERO) && (vcnt_r == V_ZERO);
            if (pop_s) begin
                rgb_nxt_s = rgb_t'(fifo_rdata);
            end else begin
                rgb_nxt_s = RGB_BLACK;
            end
            if (active_s && fifo_empty) begin
                underflow_nxt_s = 1'b1;
            end else begin
                underflow_nxt_s = underflow_r;
            end
        end else begin
            hs_nxt_s          = 1'b1;
            vs_nxt_s          = 1'b1;
            de_nxt_s          = 1'b0;
            rgb_nxt_s         = RGB_BLACK;
            frame_start_nxt_s = 1'b0;
            underflow_nxt_s   = underflow_r;
        end
    end

    // Video output registers, all one cycle behind the raster position.
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            de_r          <= 1'b0;
            rgb_r         <= RGB_BLACK;
            frame_start_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            hs_r          <= hs_nxt_s;
            vs_r          <= vs_nxt_s;
            de_r          <= de_nxt_s;
            rgb_r         <= rgb_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            underflow_r   <= underflow_nxt_s;
        end
    end

    assign fifo_read   = pop_s;
    assign video_hs    = hs_r;
    assign video_vs    = vs_r;
    assign video_de    = de_r;
    assign video_rgb   = rgb_r;
    assign frame_start = frame_start_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster, checked against a
// position-based raster model and a queue model of the pixel FIFO.
module tb_vga_timing_gen;

    localparam int HDISP  = 8;
    localparam int HFP    = 2;
    localparam int HPULSE = 3;
    localparam int HBP    = 2;
    localparam int VDISP  = 4;
    localparam int VFP    = 1;
    localparam int VPULSE = 2;
    localparam int VBP    = 1;
    localparam int HT     = HDISP + HFP + HPULSE + HBP;
    localparam int VT     = VDISP + VFP + VPULSE + VBP;
    localparam int FT     = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] rdata;
    logic        empty;
    logic        wfull;
    logic        fifo_read;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;
    logic        frame_start;
    logic        underflow;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) u_dut (
        .pixel_clk   (clk),
        .pixel_rst_n (rst_n),
        .fifo_rdata  (rdata),
        .fifo_empty  (empty),
        .fifo_wfull  (wfull),
        .fifo_read   (fifo_read),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_rgb   (video_rgb),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [23:0] q[$];
    bit          have_exp  = 1'b0;
    bit          fill_inc  = 1'b0;
    bit          rand_data = 1'b0;
    bit          seq_chk   = 1'b0;
    logic [23:0] fill_val  = 24'd1;
    logic [23:0] seq_val   = 24'd1;

    // raster model: position within the frame since the run began
    bit          m_run = 1'b0;
    int          m_pos = 0;
    bit          m_uf  = 1'b0;
    logic        e_hs, e_vs, e_de, e_fs, e_uf;
    logic [23:0] e_rgb;

    // per-frame and per-line aggregate trackers
    bit fs_seen   = 1'b0;
    bit w_dirty   = 1'b0;
    int w_cyc = 0, w_de = 0, w_hs = 0, w_vs = 0, w_pop = 0;
    int last_fall = -1;
    logic prev_hs = 1'b1;

    bit rec_start = 1'b0;
    int first_rd = -1, first_fs = -1, first_de = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic track_outputs();
        if (frame_start) begin
            if (fs_seen) begin
                check_eq("frame_period", 32'(w_cyc), 32'(FT));
                check_eq("frame_de",     32'(w_de),  32'(HDISP * VDISP));
                check_eq("frame_hs_low", 32'(w_hs),  32'(HPULSE * VT));
                check_eq("frame_vs_low", 32'(w_vs),  32'(VPULSE * HT));
                if (!w_dirty) check_eq("frame_pops", 32'(w_pop), 32'(HDISP * VDISP));
            end
            fs_seen = 1'b1;
            w_dirty = 1'b0;
            w_cyc = 0; w_de = 0; w_hs = 0; w_vs = 0; w_pop = 0;
        end
        w_cyc++;
        w_de += int'(video_de);
        w_hs += int'(!video_hs);
        w_vs += int'(!video_vs);
        if (prev_hs && !video_hs) begin
            if (last_fall >= 0) check_eq("line_period", 32'(cyc - last_fall), 32'(HT));
            last_fall = cyc;
        end
        prev_hs = video_hs;
        if (seq_chk && video_de) begin
            check_eq("rgb_seq", 32'(video_rgb), 32'(seq_val));
            seq_val++;
        end
        if (rec_start) begin
            if (frame_start && first_fs < 0) first_fs = cyc;
            if (video_de && first_de < 0) first_de = cyc;
        end
    endtask

    // One pixel clock: check last prediction, drive inputs, check the pop, predict.
    task automatic step(input logic rst_in, input logic wf_in, input logic force_e);
        int   x, y;
        bit   act;
        logic rd_exp;
        if (have_exp) begin
            check_eq("hs",          32'(video_hs),    32'(e_hs));
            check_eq("vs",          32'(video_vs),    32'(e_vs));
            check_eq("de",          32'(video_de),    32'(e_de));
            check_eq("rgb",         32'(video_rgb),   32'(e_rgb));
            check_eq("frame_start", 32'(frame_start), 32'(e_fs));
            check_eq("underflow",   32'(underflow),   32'(e_uf));
            track_outputs();
        end
        if (fill_inc && q.size() < 8) begin
            q.push_back(fill_val);
            fill_val++;
        end else if (rand_data && q.size() < 8 && $urandom_range(3, 0) != 0) begin
            q.push_back(24'($urandom));
        end
        rst_n = rst_in;
        wfull = wf_in;
        empty = force_e || (q.size() == 0);
        rdata = (q.size() != 0) ? q[0] : 24'($urandom);
        #1;
        x      = m_pos % HT;
        y      = m_pos / HT;
        act    = m_run && (x < HDISP) && (y < VDISP);
        rd_exp = act && !empty;
        if (have_exp) check_eq("fifo_read", 32'(fifo_read), 32'(rd_exp));
        w_pop += int'(fifo_read === 1'b1);
        if (act && empty) w_dirty = 1'b1;
        if (rec_start && fifo_read === 1'b1 && first_rd < 0) first_rd = cyc;

        if (!rst_in) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 24'h0; e_fs = 1'b0;
            m_run = 1'b0; m_pos = 0; m_uf = 1'b0; e_uf = 1'b0;
            fs_seen = 1'b0; last_fall = -1;
        end else if (!m_run) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 24'h0; e_fs = 1'b0;
            e_uf = m_uf;
            if (wf_in) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            e_de  = act;
            e_rgb = rd_exp ? q[0] : 24'h0;
            e_hs  = !((x >= HDISP + HFP) && (x < HDISP + HFP + HPULSE));
            e_vs  = !((y >= VDISP + VFP) && (y < VDISP + VFP + VPULSE));
            e_fs  = (m_pos == 0);
            if (act && empty) m_uf = 1'b1;
            e_uf  = m_uf;
            m_pos = (m_pos + 1) % FT;
        end
        if (rd_exp) void'(q.pop_front());
        have_exp = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int  wf_cyc;
        bit  found;
        rst_n = 1'b0;
        wfull = 1'b0;
        empty = 1'b1;
        rdata = 24'h0;

        repeat (3) step(1'b0, 1'b0, 1'b0);

        // long hold without fill: must stay idle whatever the FIFO shows
        rand_data = 1'b1;
        repeat (1000) step(1'b1, 1'b0, 1'($urandom_range(1, 0)));

        // start condition and incrementing data path
        step(1'b0, 1'b0, 1'b0);
        q.delete();
        rand_data = 1'b0;
        fill_inc  = 1'b1;
        fill_val  = 24'd1;
        seq_val   = 24'd1;
        seq_chk   = 1'b1;
        rec_start = 1'b1;
        repeat (50) step(1'b1, 1'b0, 1'b0);
        wf_cyc = cyc;
        step(1'b1, 1'b1, 1'b0);
        repeat (3 * FT) step(1'b1, 1'b0, 1'b0);
        rec_start = 1'b0;
        check_eq("start_read_lat", 32'(first_rd - wf_cyc), 32'd1);
        check_eq("start_fs_lat",   32'(first_fs - wf_cyc), 32'd2);
        check_eq("start_de_lat",   32'(first_de - wf_cyc), 32'd2);

        // underflow on active pixels 3-4 of line 1
        seq_chk = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            int x, y;
            x = m_pos % HT;
            y = m_pos / HT;
            step(1'b1, 1'b0, 1'(y == 1 && (x == 3 || x == 4)));
        end
        check_eq("underflow_sticky", 32'(underflow), 32'd1);

        // random data, random empties, random wfull while running
        fill_inc  = 1'b0;
        rand_data = 1'b1;
        repeat (3 * FT) step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(7, 0) == 0));

        // reset in the middle of a frame at (5,2)
        rand_data = 1'b0;
        fill_inc  = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (m_run && (m_pos % HT) == 5 && (m_pos / HT) == 2) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 1'b0);
        end
        check_eq("midreset_found", 32'(found), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("midreset_uf_clear", 32'(underflow), 32'd0);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (2 * FT) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
